// File: rtl/main_core_port_arbiter_pkg.sv
// Shared encodings for the serial-command port arbiter: FSM states and requester indices.
package main_core_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_SEQ  = 1'b1;

endpackage

// File: rtl/main_core_port_arbiter_if.sv
// Requester-side and core-side handshake bundle of the serial-command port arbiter.
// master: the arbiter's view; slave: the requesters and core around it.
interface main_core_port_arbiter_if #(
    parameter int unsigned CMD_W  = 16,
    parameter int unsigned DATA_W = 64
);
    logic [1:0]          req_lock;
    logic [2*CMD_W-1:0]  req_cmd;
    logic [1:0]          req_cmd_hasAny;
    logic [1:0]          req_cmd_consume;
    logic [2*DATA_W-1:0] req_in;
    logic [1:0]          req_in_isReady;
    logic [1:0]          req_in_canReceive;
    logic [DATA_W-1:0]   req_out;
    logic [1:0]          req_out_isReady;
    logic [1:0]          req_out_canReceive;
    logic [CMD_W-1:0]    cmd;
    logic                cmd_hasAny;
    logic                cmd_consume;
    logic [DATA_W-1:0]   in;
    logic                in_isReady;
    logic                in_canReceive;
    logic [DATA_W-1:0]   out;
    logic                out_isReady;
    logic                out_canReceive;

    modport master (
        input  req_lock, req_cmd, req_cmd_hasAny, req_in, req_in_isReady, req_out_canReceive,
        input  cmd_consume, in_canReceive, out, out_isReady,
        output req_cmd_consume, req_in_canReceive, req_out, req_out_isReady,
        output cmd, cmd_hasAny, in, in_isReady, out_canReceive
    );

    modport slave (
        output req_lock, req_cmd, req_cmd_hasAny, req_in, req_in_isReady, req_out_canReceive,
        output cmd_consume, in_canReceive, out, out_isReady,
        input  req_cmd_consume, req_in_canReceive, req_out, req_out_isReady,
        input  cmd, cmd_hasAny, in, in_isReady, out_canReceive
    );

endinterface

// File: rtl/main_core_port_arbiter.sv
// Round-robin lock arbiter sharing the core's cmd/in/out port between host and sequencer.
// Optional idle-timeout forced release: define MAIN_CORE_PORT_ARBITER_TIMEOUT_EN.
module main_core_port_arbiter
    import main_core_port_arbiter_pkg::*;
#(
    parameter int unsigned CMD_W    = 16,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned MAX_HOLD = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    main_core_port_arbiter_if.master bus,
    output logic [1:0]               grant,
    output logic                     timeout_err
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic [1:0] eligible;
    logic       force_release;
    logic       fwd;

    // Forwarding is cut in the very cycle the owner's lock drops.
    assign fwd = (state_q == ARB_OWN) && bus.req_lock[owner_q];

`ifdef MAIN_CORE_PORT_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      blocked_q, blocked_d;
    logic            err_q, err_d;
    logic            xfer_done;

    assign xfer_done = (bus.cmd_hasAny && bus.cmd_consume) ||
                       (bus.in_isReady && bus.in_canReceive) ||
                       (bus.out_isReady && bus.out_canReceive);
    assign force_release = fwd && (32'(cnt_q) + 32'd1 == MAX_HOLD);
    assign eligible      = bus.req_lock & ~blocked_q;
    assign timeout_err   = err_q;

    always_comb begin
        cnt_d     = '0;
        err_d     = err_q || force_release;
        // A timed-out requester stays blocked until its lock has been seen low.
        blocked_d = blocked_q & bus.req_lock;
        if (state_q == ARB_OWN && !xfer_done) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (force_release) begin
            blocked_d[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            blocked_q <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            blocked_q <= blocked_d;
            err_q     <= err_d;
        end
    end
`else
    logic [31:0] unused_max_hold;

    assign unused_max_hold = MAX_HOLD;
    assign force_release   = 1'b0;
    assign eligible        = bus.req_lock;
    assign timeout_err     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (eligible != 2'b00) begin
                    state_d = ARB_OWN;
                    owner_d = (eligible == 2'b11) ? ~last_owner_q : eligible[REQ_SEQ];
                end
            end
            ARB_OWN: begin
                if (!bus.req_lock[owner_q] || force_release) begin
                    state_d      = ARB_IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= REQ_HOST;
            last_owner_q <= REQ_SEQ;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        bus.cmd                = '0;
        bus.cmd_hasAny         = 1'b0;
        bus.in                 = '0;
        bus.in_isReady         = 1'b0;
        bus.out_canReceive     = 1'b0;
        bus.req_cmd_consume    = 2'b00;
        bus.req_in_canReceive  = 2'b00;
        bus.req_out_isReady    = 2'b00;
        bus.req_out            = bus.out;
        if (fwd) begin
            bus.cmd = owner_q ? bus.req_cmd[2*CMD_W-1:CMD_W] : bus.req_cmd[CMD_W-1:0];
            bus.in  = owner_q ? bus.req_in[2*DATA_W-1:DATA_W] : bus.req_in[DATA_W-1:0];
            bus.cmd_hasAny                 = bus.req_cmd_hasAny[owner_q];
            bus.in_isReady                 = bus.req_in_isReady[owner_q];
            bus.out_canReceive             = bus.req_out_canReceive[owner_q];
            bus.req_cmd_consume[owner_q]   = bus.cmd_consume;
            bus.req_in_canReceive[owner_q] = bus.in_canReceive;
            bus.req_out_isReady[owner_q]   = bus.out_isReady;
        end
    end

    assign grant = (state_q == ARB_OWN) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_main_core_port_arbiter.sv
// Directed self-checking bench for main_core_port_arbiter (both macro builds).
module tb_main_core_port_arbiter;

    localparam int unsigned CMD_W    = 16;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned MAX_HOLD = 8;

    logic       clk;
    logic       rst;
    logic [1:0] grant;
    logic       timeout_err;
    int         checks;
    int         failures;

    main_core_port_arbiter_if #(.CMD_W(CMD_W), .DATA_W(DATA_W)) bus ();

    main_core_port_arbiter #(
        .CMD_W   (CMD_W),
        .DATA_W  (DATA_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_lock           = 2'b00;
        bus.req_cmd            = '0;
        bus.req_cmd_hasAny     = 2'b00;
        bus.req_in             = '0;
        bus.req_in_isReady     = 2'b00;
        bus.req_out_canReceive = 2'b00;
        bus.cmd_consume        = 1'b0;
        bus.in_canReceive      = 1'b0;
        bus.out                = '0;
        bus.out_isReady        = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        // Core-side strobes active while idle must not leak through.
        bus.cmd_consume = 1'b1;
        bus.in_canReceive = 1'b1;
        bus.out_isReady = 1'b1;
        bus.req_cmd_hasAny = 2'b11;
        bus.req_in_isReady = 2'b11;
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b exp 00", grant); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", timeout_err); end
        checks++; if ({bus.cmd_hasAny, bus.in_isReady, bus.out_canReceive} !== 3'b000) begin
            failures++; $display("FAIL reset_core_hs: got %b exp 000", {bus.cmd_hasAny, bus.in_isReady, bus.out_canReceive}); end
        checks++; if ({bus.req_cmd_consume, bus.req_in_canReceive, bus.req_out_isReady} !== 6'b0) begin
            failures++; $display("FAIL reset_req_hs: got %b exp 000000", {bus.req_cmd_consume, bus.req_in_canReceive, bus.req_out_isReady}); end
        checks++; if (bus.cmd !== 16'h0 || bus.in !== 64'h0) begin
            failures++; $display("FAIL reset_data: got cmd=%h in=%h exp 0", bus.cmd, bus.in); end
        clear_inputs();
    endtask

    task automatic test_host_only();
        bus.req_lock = 2'b01;
        bus.req_cmd[15:0] = 16'h0012;
        bus.req_cmd_hasAny = 2'b01;
        #1;
        checks++; if (grant !== 2'b00 || bus.cmd_hasAny !== 1'b0) begin
            failures++; $display("FAIL host_idle: got grant=%b hasAny=%b exp 00/0", grant, bus.cmd_hasAny); end
        tick();
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL host_grant: got %b exp 01", grant); end
        checks++; if (bus.cmd !== 16'h0012 || bus.cmd_hasAny !== 1'b1) begin
            failures++; $display("FAIL host_cmd: got %h/%b exp 0012/1", bus.cmd, bus.cmd_hasAny); end
        checks++; if (bus.req_cmd_consume !== 2'b00) begin
            failures++; $display("FAIL host_noconsume: got %b exp 00", bus.req_cmd_consume); end
        bus.cmd_consume = 1'b1;
        #1;
        checks++; if (bus.req_cmd_consume !== 2'b01) begin
            failures++; $display("FAIL host_consume: got %b exp 01", bus.req_cmd_consume); end
        tick();
        bus.cmd_consume = 1'b0;
        bus.req_cmd_hasAny = 2'b00;
        bus.req_lock = 2'b00;
        #1;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL host_grant_hold: got %b exp 01", grant); end
        tick();
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL host_release: got %b exp 00", grant); end
        clear_inputs();
    endtask

    task automatic test_contention();
        apply_reset();
        bus.req_lock = 2'b11;
        tick();
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL cont_first: got %b exp 01", grant); end
        bus.req_lock = 2'b10;
        tick();
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL cont_gap: got %b exp 00", grant); end
        tick();
        checks++; if (grant !== 2'b10) begin failures++; $display("FAIL cont_seq: got %b exp 10", grant); end
        bus.req_lock = 2'b11;
        tick();
        tick();
        checks++; if (grant !== 2'b10) begin failures++; $display("FAIL cont_ignore: got %b exp 10", grant); end
        bus.req_lock = 2'b01;
        tick();
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL cont_gap2: got %b exp 00", grant); end
        tick();
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL cont_host_again: got %b exp 01", grant); end
        bus.req_lock = 2'b00;
        tick();
        clear_inputs();
    endtask

    task automatic test_data_isolation();
        bus.req_lock = 2'b10;
        tick();
        checks++; if (grant !== 2'b10) begin failures++; $display("FAIL iso_grant: got %b exp 10", grant); end
        bus.req_in = {64'h0123456789ABCDEF, 64'h5555AAAA5555AAAA};
        bus.req_in_isReady = 2'b11;
        bus.in_canReceive = 1'b1;
        bus.out = 64'hDEADBEEF00000000;
        bus.out_isReady = 1'b1;
        bus.req_out_canReceive = 2'b11;
        #1;
        checks++; if (bus.in !== 64'h0123456789ABCDEF || bus.in_isReady !== 1'b1) begin
            failures++; $display("FAIL iso_in: got %h/%b exp 0123456789abcdef/1", bus.in, bus.in_isReady); end
        checks++; if (bus.req_in_canReceive !== 2'b10) begin
            failures++; $display("FAIL iso_in_ready: got %b exp 10", bus.req_in_canReceive); end
        checks++; if (bus.req_out !== 64'hDEADBEEF00000000 || bus.req_out_isReady !== 2'b10) begin
            failures++; $display("FAIL iso_out: got %h/%b exp deadbeef00000000/10", bus.req_out, bus.req_out_isReady); end
        bus.req_out_canReceive = 2'b01;
        #1;
        checks++; if (bus.out_canReceive !== 1'b0) begin
            failures++; $display("FAIL iso_out_ready: got %b exp 0", bus.out_canReceive); end
        bus.req_lock = 2'b00;
        tick();
        tick();
        clear_inputs();
    endtask

    task automatic test_mid_release();
        bus.req_lock = 2'b01;
        tick();
        bus.req_cmd[15:0] = 16'hBEEF;
        bus.req_cmd_hasAny = 2'b01;
        #1;
        checks++; if (bus.cmd_hasAny !== 1'b1) begin failures++; $display("FAIL mid_pending: got %b exp 1", bus.cmd_hasAny); end
        bus.req_lock = 2'b00;
        bus.cmd_consume = 1'b1;
        #1;
        checks++; if (bus.cmd_hasAny !== 1'b0 || bus.req_cmd_consume !== 2'b00) begin
            failures++; $display("FAIL mid_abandon: got hasAny=%b consume=%b exp 0/00", bus.cmd_hasAny, bus.req_cmd_consume); end
        tick();
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL mid_idle: got %b exp 00", grant); end
        clear_inputs();
    endtask

    task automatic test_rst_mid();
        bus.req_lock = 2'b10;
        tick();
        bus.req_in_isReady = 2'b10;
        bus.in_canReceive = 1'b1;
        bus.out_isReady = 1'b1;
        bus.req_out_canReceive = 2'b10;
        bus.req_cmd_hasAny = 2'b10;
        #1;
        checks++; if (bus.in_isReady !== 1'b1) begin failures++; $display("FAIL rst_stream: got %b exp 1", bus.in_isReady); end
        rst = 1'b1;
        tick();
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rst_grant: got %b exp 00", grant); end
        checks++; if ({bus.cmd_hasAny, bus.in_isReady, bus.out_canReceive, bus.req_in_canReceive, bus.req_out_isReady}
                      !== 7'b0) begin
            failures++; $display("FAIL rst_hs: got %b exp 0000000",
                {bus.cmd_hasAny, bus.in_isReady, bus.out_canReceive, bus.req_in_canReceive, bus.req_out_isReady}); end
        rst = 1'b0;
        clear_inputs();
        bus.req_lock = 2'b11;
        tick();
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rst_regrant: got %b exp 01", grant); end
        bus.req_lock = 2'b00;
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        apply_reset();
`ifdef MAIN_CORE_PORT_ARBITER_TIMEOUT_EN
        bus.req_lock = 2'b11;
        tick();
        repeat (MAX_HOLD - 1) tick();
        checks++; if (grant !== 2'b01 || timeout_err !== 1'b0) begin
            failures++; $display("FAIL to_last_own: got %b/%b exp 01/0", grant, timeout_err); end
        tick();
        checks++; if (grant !== 2'b00 || timeout_err !== 1'b1) begin
            failures++; $display("FAIL to_forced: got %b/%b exp 00/1", grant, timeout_err); end
        tick();
        checks++; if (grant !== 2'b10) begin failures++; $display("FAIL to_other: got %b exp 10", grant); end
        bus.req_lock = 2'b01;
        tick();
        tick();
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL to_blocked: got %b exp 00", grant); end
        bus.req_lock = 2'b00;
        tick();
        bus.req_lock = 2'b01;
        tick();
        checks++; if (grant !== 2'b01 || timeout_err !== 1'b1) begin
            failures++; $display("FAIL to_unblocked: got %b/%b exp 01/1", grant, timeout_err); end
        apply_reset();
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clear: got %b exp 0", timeout_err); end
`else
        bus.req_lock = 2'b01;
        tick();
        repeat (3 * MAX_HOLD) tick();
        checks++; if (grant !== 2'b01 || timeout_err !== 1'b0) begin
            failures++; $display("FAIL hold_forever: got %b/%b exp 01/0", grant, timeout_err); end
        bus.req_lock = 2'b00;
        tick();
`endif
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_host_only();
        test_contention();
        test_data_isolation();
        test_mid_release();
        test_rst_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_core_port_arbiter.md
Name: main_core_port_arbiter

Overview:
- Shares the single serial-command port of main_core_serialCmd between two requesters: requester 0 is the host bridge, requester 1 is the on-chip sequencer.
- Each requester takes ownership with a lock signal. While it holds the lock it owns the cmd, in and out handshake channels exclusively.
- Ownership is granted round-robin. The arbiter's outputs connect directly to the core's cmd/in/out ports.

Parameters:
- CMD_W, 16, width of one serial command word (set to MainCoreCMD_which_SIZE+MainCoreSerialCMD_SIZE at instantiation).
- DATA_W, 64, data word width on the in/out streams.
- MAX_HOLD, 1024, idle-cycle limit before forced release (used only with the timeout feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_lock  in  2  per-requester ownership request; held for the whole session
- req_cmd  in  2*CMD_W  per-requester command; slice r is [r*CMD_W+:CMD_W]
- req_cmd_hasAny  in  2  per-requester command valid
- req_cmd_consume  out  2  per-requester command accepted
- req_in  in  2*DATA_W  per-requester input data
- req_in_isReady  in  2  per-requester input valid
- req_in_canReceive  out  2  per-requester input ready
- req_out  out  DATA_W  output data, broadcast to both requesters
- req_out_isReady  out  2  per-requester output valid
- req_out_canReceive  in  2  per-requester output ready
- cmd  out  CMD_W  command to core
- cmd_hasAny  out  1  command valid to core
- cmd_consume  in  1  core accepted command
- in  out  DATA_W  data to core
- in_isReady  out  1  data valid to core
- in_canReceive  in  1  core can accept data
- out  in  DATA_W  data from core
- out_isReady  in  1  core data valid
- out_canReceive  out  1  ready to core
- grant  out  2  one-hot current owner; 0 when idle
- timeout_err  out  1  sticky forced-release flag

Behaviour:
- State machine has two states: IDLE and OWN. Registers are state, owner (1 bit), last_owner (1 bit).
- Reset: state=IDLE, last_owner=1, so requester 0 wins the first contention. grant=0, timeout_err=0. All handshake outputs are 0; cmd and in are driven to 0.
- IDLE:
  - If exactly one req_lock bit is high, that requester becomes owner.
  - If both are high, owner = ~last_owner.
  - Transition to OWN on the next edge. There is no forwarding during IDLE.
- OWN, forwarding is purely combinational from state/owner:
  - cmd = req_cmd[owner]; cmd_hasAny = req_cmd_hasAny[owner]; req_cmd_consume[owner] = cmd_consume.
  - in = req_in[owner]; in_isReady = req_in_isReady[owner]; req_in_canReceive[owner] = in_canReceive.
  - req_out_isReady[owner] = out_isReady; out_canReceive = req_out_canReceive[owner]; req_out = out always.
  - All non-owner handshake outputs are held at 0.
- Release:
  - In OWN, if req_lock[owner] is sampled low, the next state is IDLE and last_owner takes the value of owner.
  - Forwarding stops in the same cycle the lock drops, gated combinationally by req_lock[owner].
  - At least one IDLE cycle always separates two ownership sessions.
- Grant latency: lock sampled high at edge N puts grant valid in cycle N+1. First forwarded transfer is possible in cycle N+1.
- A lock raised by the non-owner during OWN is ignored until the next IDLE.
- Lock dropped with a handshake pending: the handshake is abandoned and nothing is consumed. Requesters drop the lock only after their final transfer.
- rst mid-session: immediate return to reset values on the next edge; in-flight core transfer state is not the arbiter's responsibility.
- grant = (state==OWN) ? onehot(owner) : 2'b00.

Optional Feature:
- Macro: MAIN_CORE_PORT_ARBITER_TIMEOUT_EN.
- When defined:
  - An idle counter (clog2(MAX_HOLD+1) bits) is cleared on entry to OWN and on any completed handshake on cmd, in or out (valid&&ready).
  - Otherwise it increments each OWN cycle.
  - When it reaches MAX_HOLD, the arbiter forces state to IDLE, updates last_owner, and sets timeout_err.
  - timeout_err clears only on rst.
  - After a forced release, that requester is not re-granted until its lock has been seen low at least once.
- When undefined: there is no counter, timeout_err is tied to 0, and ownership lasts until the lock drops.

Decomposition:
- Shared package/header holds:
  - state encodings (ARB_IDLE=0, ARB_OWN=1);
  - the requester index constants REQ_HOST=0 and REQ_SEQ=1.
- No sub-module; the mux/demux is inline. The timeout counter stays inline under the macro.

Test Plan:
- Host only: req_lock=01, send cmd 0x0012 -> grant=01 one cycle after lock; cmd_hasAny rises; req_cmd_consume[0] pulses with cmd_consume; grant=00 one cycle after lock drops.
- Contention after reset: req_lock=11 -> grant=01. Host releases -> one IDLE cycle, then grant=10. Host re-locks during this session -> ignored until the sequencer releases, then grant=01.
- Data isolation: owner 1 streams 64'h0123456789ABCDEF in and receives 64'hDEADBEEF00000000 out -> requester 0's req_in_canReceive and req_out_isReady stay 0 throughout; values pass unchanged.
- Mid-handshake release: owner holds req_cmd_hasAny=1 with cmd_consume=0 and drops the lock -> cmd_hasAny=0 in the same cycle, nothing consumed, state IDLE next edge.
- rst during OWN with active stream -> next cycle grant=00, all handshake outputs 0; then req_lock=11 -> grant=01.
- With the timeout macro and MAX_HOLD=8: owner holds the lock with no transfers -> forced release after 8 OWN cycles, timeout_err=1, other requester granted next; timeout_err persists until rst.
